alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle 6502-style ALU with start/valid handshake and digit-serial BCD adjust.
//  Sits between the register file / operand latches and the status register, clocked on phi1.
//  Replaces the single-cycle ALU: adds SBC, shifts/rotates, INC/DEC, true decimal mode, and a flag set.
// PARAMETERS
//  WIDTH      8   operand/result width; must be a multiple of 4 and >= 4
//  FUNC_W     4   width of func opcode
// PORTS
//  phi1          in   1        clock; all state updates on posedge phi1
//  reset         in   1        synchronous, active-high reset
//  start         in   1        request; sampled only in IDLE
//  func          in   FUNC_W   0 ADC,1 SBC,2 AND,3 OR,4 XOR,5 ASL,6 LSR,7 ROL,8 ROR,9 INC,10 DEC
//  a             in   WIDTH    operand A
//  b             in   WIDTH    operand B (ignored for 5..10)
//  carry_in      in   1        C flag in
//  dec_mode      in   1        D flag; affects ADC/SBC only
//  busy          out  1        high from cycle after accepted start until valid cycle inclusive
//  valid         out  1        one-cycle pulse; result/flags valid
//  dout          out  WIDTH    registered result, holds until next valid
//  carry_out     out  1        C
//  zero_out      out  1        Z = (dout == 0)
//  overflow_out  out  1        V
//  neg_out       out  1        N = dout[WIDTH-1]
// BEHAVIOUR
//  Reset: state IDLE; dout, all flags, busy, valid = 0. Reset in any state aborts; no valid issued.
//  FSM IDLE -> EXEC -> (ADJUST x WIDTH/4) -> DONE -> IDLE.
//  IDLE: start=1 latches a,b,func,carry_in,dec_mode; next EXEC. start outside IDLE ignored.
//  EXEC: binary result r. ADC r=a+b+cin; SBC r=a+~b+cin; C = carry out of MSB (SBC: C=1 no borrow).
//   V (ADC/SBC) = msb of (a^r)&(b'^r), b'=b (ADC) or ~b (SBC), always from binary result.
//   AND/OR/XOR: C=cin, V=0. ASL C=a[W-1], LSR C=a[0], ROL/ROR shift cin in, C=bit shifted out; V=0.
//   INC/DEC: a+/-1 mod 2^WIDTH, C=cin, V=0. Undefined func: dout=a, C=cin, V=0.
//   dec_mode && func in {ADC,SBC} -> ADJUST (digit k=0), else -> DONE.
//  ADJUST: one 4-bit digit per cycle, LSD first; dc initialised to cin.
//   ADC: s=a_k+b_k+dc (5b); s>9 -> digit=(s+6)[3:0], dc=1; else digit=s[3:0], dc=0.
//   SBC: s=a_k-b_k-(~dc); s<0 -> digit=(s-6)[3:0], dc=0; else digit=s[3:0], dc=1.
//   Digits >9 in input not checked; rule above applied as-is. After last digit C=dc, -> DONE.
//  DONE: dout/flags registered, valid=1, busy=1; next IDLE (busy=0). Z,N from final dout.
//  Latency start->valid: 2 cycles binary; 2+WIDTH/4 cycles decimal ADC/SBC.
//  Back-to-back: start may be asserted in the IDLE cycle right after DONE.
//  Inputs changing after acceptance have no effect on the in-flight operation.
// TESTING
//  ADC bin W=8 a=50 b=50 cin=0 -> dout A0 C0 V1 N1 Z0, valid 2 cycles after start.
//  ADC dec a=58 b=46 cin=1 -> dout 05 C1 Z0, valid 4 cycles after start; busy high 4 cycles.
//  SBC dec a=12 b=21 cin=1 -> dout 91 C0 N1; SBC bin a=00 b=01 cin=1 -> FF C0 N1 V0.
//  ROR a=01 cin=1 -> dout 80 C1 N1; LSR a=01 -> dout 00 C1 Z1.
//  start re-pulsed during ADJUST ignored; reset in ADJUST -> next cycle all outputs 0, no valid.
//  W=16: ADC FFFF+0001 cin=0 -> 0000 C1 Z1 V0; dec ADC 9999+0001 -> 0000 C1, valid at cycle 6.

Source files
------------

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : multi-cycle 6502-style ALU with start/valid handshake and
//           digit-serial BCD adjust for decimal-mode ADC/SBC.
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int FUNC_W = 4
) (
  input  logic              phi1,
  input  logic              reset,
  input  logic              start,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              carry_in,
  input  logic              dec_mode,
  output logic              busy,
  output logic              valid,
  output logic [WIDTH-1:0]  dout,
  output logic              carry_out,
  output logic              zero_out,
  output logic              overflow_out,
  output logic              neg_out
);

  localparam int c_ndig  = WIDTH / 4;
  localparam int c_cnt_w = (c_ndig > 1) ? $clog2(c_ndig) : 1;

  localparam logic [FUNC_W-1:0] c_adc = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] c_sbc = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] c_and = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] c_or  = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] c_xor = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] c_asl = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] c_lsr = FUNC_W'(6);
  localparam logic [FUNC_W-1:0] c_rol = FUNC_W'(7);
  localparam logic [FUNC_W-1:0] c_ror = FUNC_W'(8);
  localparam logic [FUNC_W-1:0] c_inc = FUNC_W'(9);
  localparam logic [FUNC_W-1:0] c_dec = FUNC_W'(10);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_ADJUST = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [FUNC_W-1:0]  r_op_func;
  logic               r_op_cin;
  logic               r_op_dec;
  logic [WIDTH-1:0]   r_acc;
  logic               r_dc;
  logic               r_v_hold;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_dout;
  logic               r_c;
  logic               r_z;
  logic               r_v;
  logic               r_n;

  logic               w_is_sbc;
  logic               w_is_arith;
  logic               w_go_adjust;
  logic [WIDTH-1:0]   w_bop;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_vvec;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  logic [3:0]         w_ad;
  logic [3:0]         w_bd;
  logic [4:0]         w_sadd;
  logic [4:0]         w_sadd_adj;
  logic [5:0]         w_ssub;
  logic [5:0]         w_ssub_adj;
  logic [3:0]         w_digit;
  logic               w_dc;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_last;

  assign w_is_sbc    = (r_op_func == c_sbc);
  assign w_is_arith  = (r_op_func == c_adc) || w_is_sbc;
  assign w_go_adjust = r_op_dec && w_is_arith;

  // Binary datapath; V always comes from the binary sum, even in decimal mode
  assign w_bop  = w_is_sbc ? ~r_op_b : r_op_b;
  assign w_sum  = {1'b0, r_op_a} + {1'b0, w_bop} + (WIDTH+1)'(r_op_cin);
  assign w_vvec = (r_op_a ^ w_sum[WIDTH-1:0]) & (w_bop ^ w_sum[WIDTH-1:0]);

  always_comb begin
    w_res = r_op_a;
    w_c   = r_op_cin;
    w_v   = 1'b0;
    case (r_op_func)
      c_adc, c_sbc: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_vvec[WIDTH-1];
      end
      c_and: w_res = r_op_a & r_op_b;
      c_or:  w_res = r_op_a | r_op_b;
      c_xor: w_res = r_op_a ^ r_op_b;
      c_asl: begin
        w_res = {r_op_a[WIDTH-2:0], 1'b0};
        w_c   = r_op_a[WIDTH-1];
      end
      c_lsr: begin
        w_res = {1'b0, r_op_a[WIDTH-1:1]};
        w_c   = r_op_a[0];
      end
      c_rol: begin
        w_res = {r_op_a[WIDTH-2:0], r_op_cin};
        w_c   = r_op_a[WIDTH-1];
      end
      c_ror: begin
        w_res = {r_op_cin, r_op_a[WIDTH-1:1]};
        w_c   = r_op_a[0];
      end
      c_inc: w_res = r_op_a + WIDTH'(1);
      c_dec: w_res = r_op_a - WIDTH'(1);
      default: ;
    endcase
  end

  // Decimal adjust: operands shift right one digit per cycle, result digits
  // enter the accumulator at the top so the final digit lands in place.
  assign w_ad       = r_op_a[3:0];
  assign w_bd       = r_op_b[3:0];
  assign w_sadd     = {1'b0, w_ad} + {1'b0, w_bd} + {4'b0, r_dc};
  assign w_sadd_adj = w_sadd + 5'd6;
  assign w_ssub     = {2'b0, w_ad} - {2'b0, w_bd} - {5'b0, ~r_dc};
  assign w_ssub_adj = w_ssub - 6'd6;

  always_comb begin
    w_digit = w_sadd[3:0];
    w_dc    = 1'b0;
    if (w_is_sbc) begin
      if (w_ssub[5]) begin
        w_digit = w_ssub_adj[3:0];
        w_dc    = 1'b0;
      end else begin
        w_digit = w_ssub[3:0];
        w_dc    = 1'b1;
      end
    end else if (w_sadd > 5'd9) begin
      w_digit = w_sadd_adj[3:0];
      w_dc    = 1'b1;
    end
  end

  assign w_acc_next = (WIDTH'(w_digit) << (WIDTH - 4)) | (r_acc >> 4);
  assign w_last     = (r_cnt == c_cnt_w'(c_ndig - 1));

  always_ff @(posedge phi1) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_EXEC;
      S_EXEC:   w_next = w_go_adjust ? S_ADJUST : S_DONE;
      S_ADJUST: if (w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge phi1) begin
    if (reset) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_op_func <= '0;
      r_op_cin  <= 1'b0;
      r_op_dec  <= 1'b0;
      r_acc     <= '0;
      r_dc      <= 1'b0;
      r_v_hold  <= 1'b0;
      r_cnt     <= '0;
      r_dout    <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_v       <= 1'b0;
      r_n       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_a    <= a;
            r_op_b    <= b;
            r_op_func <= func;
            r_op_cin  <= carry_in;
            r_op_dec  <= dec_mode;
          end
        end
        S_EXEC: begin
          if (w_go_adjust) begin
            r_dc     <= r_op_cin;
            r_v_hold <= w_v;
            r_cnt    <= '0;
            r_acc    <= '0;
          end else begin
            r_dout <= w_res;
            r_c    <= w_c;
            r_v    <= w_v;
            r_z    <= (w_res == '0);
            r_n    <= w_res[WIDTH-1];
          end
        end
        S_ADJUST: begin
          r_op_a <= r_op_a >> 4;
          r_op_b <= r_op_b >> 4;
          r_acc  <= w_acc_next;
          r_dc   <= w_dc;
          r_cnt  <= r_cnt + c_cnt_w'(1);
          if (w_last) begin
            r_dout <= w_acc_next;
            r_c    <= w_dc;
            r_v    <= r_v_hold;
            r_z    <= (w_acc_next == '0);
            r_n    <= w_acc_next[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign valid        = (r_state == S_DONE);
  assign dout         = r_dout;
  assign carry_out    = r_c;
  assign zero_out     = r_z;
  assign overflow_out = r_v;
  assign neg_out      = r_n;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : directed self-checking bench for alu_seq at WIDTH 8 and 16.
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start8;
  logic        start16;
  logic [3:0]  func;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        cin;
  logic        dec;

  logic        busy8, valid8, c8, z8, v8, n8;
  logic [7:0]  dout8;
  logic        busy16, valid16, c16, z16, v16, n16;
  logic [15:0] dout16;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] g_dout;
  logic [3:0]  g_fl;
  int          g_lat;
  int          g_bcnt;

  alu_seq #(.WIDTH(8), .FUNC_W(4)) u_dut8 (
    .phi1(clk), .reset(rst), .start(start8), .func(func),
    .a(a_in[7:0]), .b(b_in[7:0]), .carry_in(cin), .dec_mode(dec),
    .busy(busy8), .valid(valid8), .dout(dout8), .carry_out(c8),
    .zero_out(z8), .overflow_out(v8), .neg_out(n8)
  );

  alu_seq #(.WIDTH(16), .FUNC_W(4)) u_dut16 (
    .phi1(clk), .reset(rst), .start(start16), .func(func),
    .a(a_in), .b(b_in), .carry_in(cin), .dec_mode(dec),
    .busy(busy16), .valid(valid16), .dout(dout16), .carry_out(c16),
    .zero_out(z16), .overflow_out(v16), .neg_out(n16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts one op on the selected DUT and returns at the negedge where valid is seen.
  task automatic run_op(input bit w16, input logic [3:0] f, input logic [15:0] av,
                        input logic [15:0] bv, input logic ci, input logic dm);
    bit seen;
    @(negedge clk);
    func = f; a_in = av; b_in = bv; cin = ci; dec = dm;
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    g_lat = 1; g_bcnt = 0; seen = 1'b0;
    while (g_lat <= 20 && !seen) begin
      if (w16 ? busy16 : busy8) g_bcnt++;
      if (w16 ? valid16 : valid8) seen = 1'b1;
      else begin
        @(negedge clk);
        g_lat++;
      end
    end
    if (!seen) check("valid_timeout", 32'd0, 32'd1);
    g_dout = w16 ? dout16 : {8'h00, dout8};
    g_fl   = w16 ? {c16, z16, v16, n16} : {c8, z8, v8, n8};
  endtask

  // Flags packed as {C, Z, V, N}
  task automatic op_chk(input string tag, input bit w16, input logic [3:0] f,
                        input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic dm, input logic [15:0] exp_dout,
                        input logic [3:0] exp_fl, input int exp_lat);
    run_op(w16, f, av, bv, ci, dm);
    check({tag, "_dout"}, 32'(g_dout), 32'(exp_dout));
    check({tag, "_flags"}, 32'(g_fl), 32'(exp_fl));
    check({tag, "_lat"}, 32'(g_lat), 32'(exp_lat));
  endtask

  initial begin
    int nv;
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    func = '0; a_in = '0; b_in = '0; cin = 1'b0; dec = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout8", 32'(dout8), 32'd0);
    check("reset_ctl8", 32'({busy8, valid8, c8, z8, v8, n8}), 32'd0);
    check("reset_dout16", 32'(dout16), 32'd0);
    rst = 1'b0;

    op_chk("adc_bin", 0, 4'd0, 16'h50, 16'h50, 1'b0, 1'b0, 16'hA0, 4'b0011, 2);
    @(negedge clk);
    check("hold_dout", 32'(dout8), 32'hA0);
    check("idle_ctl", 32'({busy8, valid8}), 32'd0);

    op_chk("adc_dec", 0, 4'd0, 16'h58, 16'h46, 1'b1, 1'b1, 16'h05, 4'b1010, 4);
    check("adc_dec_busy", 32'(g_bcnt), 32'd4);
    op_chk("sbc_dec", 0, 4'd1, 16'h12, 16'h21, 1'b1, 1'b1, 16'h91, 4'b0001, 4);
    op_chk("sbc_bin", 0, 4'd1, 16'h00, 16'h01, 1'b1, 1'b0, 16'hFF, 4'b0001, 2);
    op_chk("adc_ovf", 0, 4'd0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 4'b0011, 2);
    op_chk("ror", 0, 4'd8, 16'h01, 16'h55, 1'b1, 1'b0, 16'h80, 4'b1001, 2);
    op_chk("lsr", 0, 4'd6, 16'h01, 16'h00, 1'b0, 1'b0, 16'h00, 4'b1100, 2);
    op_chk("and_d", 0, 4'd2, 16'hF0, 16'h3C, 1'b1, 1'b1, 16'h30, 4'b1000, 2);
    op_chk("or", 0, 4'd3, 16'h0F, 16'h30, 1'b0, 1'b0, 16'h3F, 4'b0000, 2);
    op_chk("xor", 0, 4'd4, 16'hFF, 16'hFF, 1'b0, 1'b0, 16'h00, 4'b0100, 2);
    op_chk("asl", 0, 4'd5, 16'h81, 16'h00, 1'b0, 1'b0, 16'h02, 4'b1000, 2);
    op_chk("rol", 0, 4'd7, 16'h80, 16'h00, 1'b1, 1'b0, 16'h01, 4'b1000, 2);
    op_chk("inc", 0, 4'd9, 16'hFF, 16'h00, 1'b0, 1'b0, 16'h00, 4'b0100, 2);
    op_chk("dec", 0, 4'd10, 16'h00, 16'h00, 1'b1, 1'b0, 16'hFF, 4'b1001, 2);
    op_chk("undef", 0, 4'd15, 16'h7E, 16'h11, 1'b1, 1'b0, 16'h7E, 4'b1000, 2);

    op_chk("w16_adc", 1, 4'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1100, 2);
    op_chk("w16_dec", 1, 4'd0, 16'h9999, 16'h0001, 1'b0, 1'b1, 16'h0000, 4'b1100, 6);

    // start pulsed again mid-adjust with different operands must be ignored
    @(negedge clk);
    func = 4'd0; a_in = 16'h58; b_in = 16'h46; cin = 1'b1; dec = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    func = 4'd2; a_in = 16'h00; b_in = 16'h00; cin = 1'b0; dec = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    check("restart_valid", 32'(valid8), 32'd1);
    check("restart_dout", 32'(dout8), 32'h05);
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (valid8) nv++;
    end
    check("restart_extra_valid", 32'(nv), 32'd0);

    // reset while in ADJUST aborts the operation
    func = 4'd0; a_in = 16'h58; b_in = 16'h46; cin = 1'b1; dec = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_dout", 32'(dout8), 32'd0);
    check("abort_ctl", 32'({busy8, valid8, c8, z8, v8, n8}), 32'd0);
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid8) nv++;
    end
    check("abort_no_valid", 32'(nv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
